// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue controller and its instruction decoder.
package alu_issue_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SH_W     = 5;

    // Major opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGT   = 6'h06;
    localparam logic [5:0] OP_BGTE  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BLE   = 6'h0A;
    localparam logic [5:0] OP_BLEQ  = 6'h0B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_BEQ  = 4'd7;
    localparam logic [3:0] ALU_BNE  = 4'd8;
    localparam logic [3:0] ALU_BGT  = 4'd9;
    localparam logic [3:0] ALU_BGTE = 4'd10;
    localparam logic [3:0] ALU_BLE  = 4'd11;
    localparam logic [3:0] ALU_BLEQ = 4'd12;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // Decoded control word
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                use_imm;
        logic                wr_rt;
        logic                is_branch;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode/funct decode into ALU opcode and write-back/branch controls.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec_c
);

    // Map encodings to controls; anything unlisted is flagged illegal with alu_op 0.
    always_comb begin
        dec_c = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec_c.alu_op = ALU_ADD;
                    FN_SUB:  dec_c.alu_op = ALU_SUB;
                    FN_AND:  dec_c.alu_op = ALU_AND;
                    FN_OR:   dec_c.alu_op = ALU_OR;
                    FN_SLL:  dec_c.alu_op = ALU_SLL;
                    FN_SRL:  dec_c.alu_op = ALU_SRL;
                    FN_SLT:  dec_c.alu_op = ALU_SLT;
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_c.alu_op  = ALU_ADD;
                dec_c.use_imm = 1'b1;
                dec_c.wr_rt   = 1'b1;
            end
            OP_BEQ:  begin dec_c.alu_op = ALU_BEQ;  dec_c.is_branch = 1'b1; end
            OP_BNE:  begin dec_c.alu_op = ALU_BNE;  dec_c.is_branch = 1'b1; end
            OP_BGT:  begin dec_c.alu_op = ALU_BGT;  dec_c.is_branch = 1'b1; end
            OP_BGTE: begin dec_c.alu_op = ALU_BGTE; dec_c.is_branch = 1'b1; end
            OP_BLE:  begin dec_c.alu_op = ALU_BLE;  dec_c.is_branch = 1'b1; end
            OP_BLEQ: begin dec_c.alu_op = ALU_BLEQ; dec_c.is_branch = 1'b1; end
            default: dec_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue sequencer: accept, read operands, execute on the ALU, write back / resolve branch.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [XLEN-1:0]     instr_pc,
    output logic [RF_AW-1:0]    rf_raddr1,
    output logic [RF_AW-1:0]    rf_raddr2,
    input  logic [XLEN-1:0]     rf_rdata1,
    input  logic [XLEN-1:0]     rf_rdata2,
    output logic                rf_we,
    output logic [RF_AW-1:0]    rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [XLEN-1:0]     alu_in1,
    output logic [XLEN-1:0]     alu_in2,
    output logic [SH_W-1:0]     alu_sh_amt,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     alu_out,
    input  logic                alu_branch,
    output logic                br_valid,
    output logic                br_taken,
    output logic [XLEN-1:0]     br_target,
    output logic                done,
    output logic                illegal
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [INSTR_W-1:0] instr_q;
    logic [XLEN-1:0]    pc_q;
    logic [RF_AW-1:0]   raddr1_q;
    logic [RF_AW-1:0]   raddr2_q;
    dec_t               dec_c;
    logic               handshake_c;
    logic [XLEN-1:0]    imm_sext_c;
    logic [XLEN-1:0]    br_target_c;
    logic [RF_AW-1:0]   dest_c;

    alu_issue_decode u_decode (
        .op    (instr_q[31:26]),
        .funct (instr_q[5:0]),
        .dec_c (dec_c)
    );

    // Datapath helpers derived from the latched instruction.
    always_comb begin
        handshake_c = instr_valid & instr_ready;
        imm_sext_c  = XLEN'($signed(instr_q[15:0]));
        br_target_c = pc_q + XLEN'(4) + (imm_sext_c << 2);
        dest_c      = dec_c.wr_rt ? RF_AW'(instr_q[20:16]) : RF_AW'(instr_q[15:11]);
    end

    // Read addresses are presented during the accepting cycle so the synchronous RF
    // returns data in READ; afterwards the latched addresses are held.
    always_comb begin
        rf_raddr1 = raddr1_q;
        rf_raddr2 = raddr2_q;
        if ((state == ST_IDLE) && instr_valid && !reset) begin
            rf_raddr1 = RF_AW'(instr[25:21]);
            rf_raddr2 = RF_AW'(instr[20:16]);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: fixed one-cycle phases, only IDLE waits for an offer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (handshake_c) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered datapath and pulse outputs, updated per phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_ready <= 1'b1;
            instr_q     <= '0;
            pc_q        <= '0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_sh_amt  <= '0;
            alu_op      <= '0;
            br_valid    <= 1'b0;
            br_taken    <= 1'b0;
            br_target   <= '0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            rf_we    <= 1'b0;
            br_valid <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (handshake_c) begin
                        instr_q     <= instr;
                        pc_q        <= instr_pc;
                        raddr1_q    <= RF_AW'(instr[25:21]);
                        raddr2_q    <= RF_AW'(instr[20:16]);
                        instr_ready <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (dec_c.illegal) begin
                        alu_op <= '0;
                    end else begin
                        alu_op     <= dec_c.alu_op;
                        alu_in1    <= rf_rdata1;
                        alu_in2    <= dec_c.use_imm ? imm_sext_c : rf_rdata2;
                        alu_sh_amt <= instr_q[10:6];
                    end
                end
                ST_EXEC: begin
                    done    <= 1'b1;
                    illegal <= dec_c.illegal;
                    if (!dec_c.illegal) begin
                        if (dec_c.is_branch) begin
                            br_valid  <= 1'b1;
                            br_taken  <= alu_branch;
                            br_target <= br_target_c;
                        end else begin
                            rf_we    <= (dest_c != '0);
                            rf_waddr <= dest_c;
                            rf_wdata <= alu_out;
                        end
                    end
                end
                ST_WB: begin
                    instr_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus randomized instructions vs. a behavioural model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] instr_pc = '0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_in1, alu_in2;
    logic [4:0]  alu_sh_amt;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_branch;
    logic        br_valid, br_taken;
    logic [31:0] br_target;
    logic        done, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rf [32];

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        br;
        logic        taken;
        logic [31:0] target;
        logic        ill;
        logic [3:0]  op;
    } exp_t;

    // Observations from the most recent issue()
    logic        obs_ready0, obs_ready1, obs_ready4, obs_early, obs_late;
    logic [3:0]  obs_op;
    logic        obs_done, obs_ill, obs_we, obs_br, obs_taken;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata, obs_target;

    logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A};
    logic [5:0] br_tab [6] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h0A, 6'h0B};

    alu_issue_ctrl #(.XLEN(32), .RF_AW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_sh_amt  (alu_sh_amt),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_branch  (alu_branch),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Synchronous-read register file
    always @(posedge clk) begin
        rf_rdata1 <= rf[rf_raddr1];
        rf_rdata2 <= rf[rf_raddr2];
    end

    // Combinational ALU the controller drives
    always_comb begin
        case (alu_op)
            4'd0:  alu_out = alu_in1 + alu_in2;
            4'd1:  alu_out = alu_in1 - alu_in2;
            4'd2:  alu_out = alu_in1 & alu_in2;
            4'd3:  alu_out = alu_in1 | alu_in2;
            4'd4:  alu_out = alu_in1 << alu_sh_amt;
            4'd5:  alu_out = alu_in1 >> alu_sh_amt;
            4'd6:  alu_out = {31'd0, alu_in1 <  alu_in2};
            4'd7:  alu_out = {31'd0, alu_in1 == alu_in2};
            4'd8:  alu_out = {31'd0, alu_in1 != alu_in2};
            4'd9:  alu_out = {31'd0, alu_in1 >  alu_in2};
            4'd10: alu_out = {31'd0, alu_in1 >= alu_in2};
            4'd11: alu_out = {31'd0, alu_in1 <  alu_in2};
            4'd12: alu_out = {31'd0, alu_in1 <= alu_in2};
            default: alu_out = '0;
        endcase
        alu_branch = (alu_out != '0);
    end

    wire any_out = |{rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata, alu_in1, alu_in2,
                     alu_sh_amt, alu_op, br_valid, br_taken, br_target, done, illegal};

    // Architectural effect of one instruction given the bench register file
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] a, b, simm;
        logic [5:0]  op, fn;
        logic [4:0]  rt, rd, sh;
        op = ins[31:26]; fn = ins[5:0]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
        a = rf[ins[25:21]]; b = rf[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        e = '0;
        if (op == 6'h00) begin
            e.waddr = rd;
            case (fn)
                6'h20: begin e.op = 4'd0; e.wdata = a + b; end
                6'h22: begin e.op = 4'd1; e.wdata = a - b; end
                6'h24: begin e.op = 4'd2; e.wdata = a & b; end
                6'h25: begin e.op = 4'd3; e.wdata = a | b; end
                6'h00: begin e.op = 4'd4; e.wdata = a << sh; end
                6'h02: begin e.op = 4'd5; e.wdata = a >> sh; end
                6'h2A: begin e.op = 4'd6; e.wdata = (a < b) ? 32'd1 : 32'd0; end
                default: e.ill = 1'b1;
            endcase
            e.we = !e.ill && (rd != 5'd0);
        end else if (op == 6'h08) begin
            e.op = 4'd0; e.waddr = rt; e.wdata = a + simm; e.we = (rt != 5'd0);
        end else if (op inside {6'h04, 6'h05, 6'h06, 6'h07, 6'h0A, 6'h0B}) begin
            e.br = 1'b1;
            e.target = pc + 32'd4 + (simm << 2);
            case (op)
                6'h04:   begin e.op = 4'd7;  e.taken = (a == b); end
                6'h05:   begin e.op = 4'd8;  e.taken = (a != b); end
                6'h06:   begin e.op = 4'd9;  e.taken = (a >  b); end
                6'h07:   begin e.op = 4'd10; e.taken = (a >= b); end
                6'h0A:   begin e.op = 4'd11; e.taken = (a <  b); end
                default: begin e.op = 4'd12; e.taken = (a <= b); end
            endcase
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) e.op = 4'd0;
        return e;
    endfunction

    // Offer one instruction and record what the controller does over its five cycles
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        obs_ready0 = instr_ready;
        instr = ins; instr_pc = pc; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; instr = $urandom(); instr_pc = $urandom();
        obs_ready1 = instr_ready; obs_early = done | rf_we | br_valid;
        @(negedge clk);
        obs_op = alu_op; obs_early = obs_early | done | rf_we | br_valid;
        @(negedge clk);
        obs_done = done; obs_ill = illegal; obs_we = rf_we; obs_waddr = rf_waddr;
        obs_wdata = rf_wdata; obs_br = br_valid; obs_taken = br_taken; obs_target = br_target;
        @(negedge clk);
        obs_late = done | rf_we | br_valid; obs_ready4 = instr_ready;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (any_out !== 1'b0) $display("FAIL reset_outputs: got nonzero outputs, want all 0"); else n_pass++;
        n_checks++; if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({instr_ready, done, rf_we} !== 3'b100) $display("FAIL post_reset_idle: got %b want 100", {instr_ready, done, rf_we}); else n_pass++;
    endtask

    task automatic test_add();
        rf[1] = 32'd5; rf[2] = 32'd7;
        issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h0);
        n_checks++; if (obs_done !== 1'b1) $display("FAIL add_done: got %b want 1", obs_done); else n_pass++;
        n_checks++; if (obs_we !== 1'b1) $display("FAIL add_we: got %b want 1", obs_we); else n_pass++;
        n_checks++; if (obs_waddr !== 5'd3) $display("FAIL add_waddr: got %0d want 3", obs_waddr); else n_pass++;
        n_checks++; if (obs_wdata !== 32'd12) $display("FAIL add_wdata: got %0d want 12", obs_wdata); else n_pass++;
    endtask

    task automatic test_sll();
        rf[1] = 32'd1;
        issue({6'h00, 5'd1, 5'd0, 5'd5, 5'd4, 6'h00}, 32'h0);
        n_checks++; if (obs_op !== 4'd4) $display("FAIL sll_op: got %0d want 4", obs_op); else n_pass++;
        n_checks++; if ({obs_we, obs_wdata} !== {1'b1, 32'd16}) $display("FAIL sll_wdata: got we=%b %0d want we=1 16", obs_we, obs_wdata); else n_pass++;
    endtask

    task automatic test_beq();
        rf[6] = 32'd9; rf[7] = 32'd9;
        issue({6'h04, 5'd6, 5'd7, 16'h0003}, 32'h100);
        n_checks++; if ({obs_br, obs_taken} !== 2'b11) $display("FAIL beq_taken: got %b want 11", {obs_br, obs_taken}); else n_pass++;
        n_checks++; if (obs_target !== 32'h110) $display("FAIL beq_target: got %h want 00000110", obs_target); else n_pass++;
        n_checks++; if ({obs_we, obs_done} !== 2'b01) $display("FAIL beq_we_done: got %b want 01", {obs_we, obs_done}); else n_pass++;
    endtask

    task automatic test_bne();
        rf[6] = 32'd9; rf[7] = 32'd9;
        issue({6'h05, 5'd6, 5'd7, 16'hFFFF}, 32'h100);
        n_checks++; if ({obs_br, obs_taken} !== 2'b10) $display("FAIL bne_taken: got %b want 10", {obs_br, obs_taken}); else n_pass++;
        n_checks++; if (obs_target !== 32'h100) $display("FAIL bne_target: got %h want 00000100", obs_target); else n_pass++;
    endtask

    task automatic test_r0_and_illegal();
        rf[1] = 32'd5; rf[2] = 32'd7;
        issue({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'h0);
        n_checks++; if ({obs_done, obs_we, obs_ill} !== 3'b100) $display("FAIL r0_write: got done/we/ill=%b want 100", {obs_done, obs_we, obs_ill}); else n_pass++;
        issue({6'h3F, 26'h0ABCDEF}, 32'h0);
        n_checks++; if ({obs_done, obs_ill} !== 2'b11) $display("FAIL illegal_flag: got done/ill=%b want 11", {obs_done, obs_ill}); else n_pass++;
        n_checks++; if ({obs_we, obs_br} !== 2'b00) $display("FAIL illegal_side: got we/br=%b want 00", {obs_we, obs_br}); else n_pass++;
        n_checks++; if (obs_op !== 4'd0) $display("FAIL illegal_op: got %0d want 0", obs_op); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        rf[1] = 32'd5; rf[2] = 32'd7;
        @(negedge clk);
        instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (any_out !== 1'b0) $display("FAIL reset_mid_outputs: got nonzero outputs, want all 0"); else n_pass++;
        n_checks++; if (instr_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b want 1", instr_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done | rf_we | br_valid;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL reset_mid_abort: got retire activity %b want 0", seen); else n_pass++;
    endtask

    task automatic test_back_to_back();
        rf[1] = 32'd5; rf[2] = 32'd7;
        @(negedge clk);
        instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; instr_pc = 32'h40; instr_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) instr = {6'h08, 5'd1, 5'd4, 16'hFFFF};
            if (c == 2) begin
                n_checks++; if (instr_ready !== 1'b0) $display("FAIL b2b_busy: got ready %b want 0", instr_ready); else n_pass++;
            end
            if (c == 3) begin
                n_checks++; if ({done, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd3, 32'd12}) $display("FAIL b2b_first: got done=%b we=%b wa=%0d wd=%0d want 1 1 3 12", done, rf_we, rf_waddr, rf_wdata); else n_pass++;
            end
            if (c == 4) begin
                n_checks++; if (instr_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", instr_ready); else n_pass++;
            end
            if (c == 5) begin
                instr_valid = 1'b0;
                n_checks++; if (instr_ready !== 1'b0) $display("FAIL b2b_accept: got ready %b want 0", instr_ready); else n_pass++;
            end
            if (c == 7) begin
                n_checks++; if ({done, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd4, 32'd4}) $display("FAIL b2b_second: got done=%b we=%b wa=%0d wd=%0d want 1 1 4 4", done, rf_we, rf_waddr, rf_wdata); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ins, pc;
        logic [4:0]  rs, rt, rd, sh;
        exp_t        e;
        int          k;
        for (int n = 0; n < 40; n++) begin
            for (int i = 1; i < 32; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
            rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31)); sh = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) rt = rs;
            pc = $urandom();
            k = $urandom_range(0, 9);
            if (k <= 6)      ins = {6'h00, rs, rt, rd, sh, fn_tab[k]};
            else if (k == 7) ins = {6'h08, rs, rt, 16'($urandom())};
            else if (k == 8) ins = {br_tab[$urandom_range(0, 5)], rs, rt, 16'($urandom())};
            else             ins = $urandom();
            e = model(ins, pc);
            issue(ins, pc);
            n_checks++; if ({obs_ready0, obs_ready1, obs_early} !== 3'b100) $display("FAIL rnd%0d_handshake: got rdy0/rdy1/early=%b want 100", n, {obs_ready0, obs_ready1, obs_early}); else n_pass++;
            n_checks++; if (obs_op !== e.op) $display("FAIL rnd%0d_aluop: ins=%h got %0d want %0d", n, ins, obs_op, e.op); else n_pass++;
            n_checks++; if ({obs_done, obs_ill, obs_we, obs_br} !== {1'b1, e.ill, e.we, e.br}) $display("FAIL rnd%0d_ctrl: ins=%h got done/ill/we/br=%b want %b", n, ins, {obs_done, obs_ill, obs_we, obs_br}, {1'b1, e.ill, e.we, e.br}); else n_pass++;
            if (e.we) begin
                n_checks++; if ({obs_waddr, obs_wdata} !== {e.waddr, e.wdata}) $display("FAIL rnd%0d_wb: ins=%h got r%0d=%h want r%0d=%h", n, ins, obs_waddr, obs_wdata, e.waddr, e.wdata); else n_pass++;
            end
            if (e.br) begin
                n_checks++; if ({obs_taken, obs_target} !== {e.taken, e.target}) $display("FAIL rnd%0d_br: ins=%h got taken=%b tgt=%h want taken=%b tgt=%h", n, ins, obs_taken, obs_target, e.taken, e.target); else n_pass++;
            end
            n_checks++; if ({obs_late, obs_ready4} !== 2'b01) $display("FAIL rnd%0d_after: got late/rdy=%b want 01", n, {obs_late, obs_ready4}); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_add();
        test_sll();
        test_beq();
        test_bne();
        test_r0_and_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
